gpr_wb_sched: RTL
=================

Name: gpr_wb_sched

Overview:
- Write-back scheduler for the 32x32 general-purpose register file.
- Shares the register file's single write port among NREQ producers (ALU, load unit, mul/div unit) using round-robin arbitration.
- Keeps a busy-register scoreboard: decode reserves destination registers at issue, and operand queries report registers whose writes are still pending, so the pipeline can interlock.
- Sits between the execute/memory stages and the register-file write port (rw, wd, GPRWr).

Parameters:
- NREQ, 3, number of write-back requesters; index 0 has highest priority out of reset.
- DW, 32, data width.
- AW, 5, register address width (32 registers).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NREQ  requester i has a write pending.
- req_rw  in  NREQ*AW  destination of requester i, packed; slice i is [i*AW +: AW].
- req_wd  in  NREQ*DW  write data of requester i, packed; slice i is [i*DW +: DW].
- req_ready  out  NREQ  grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- rsv_valid  in  1  decode requests a reservation of rsv_rw.
- rsv_rw  in  AW  register to reserve.
- rsv_ready  out  1  reservation accepted this cycle.
- qa, qb  in  AW  operand registers being read by decode.
- busy_a, busy_b  out  1  the queried register has a pending write.
- gpr_we  out  1  drives GPRWr.
- gpr_rw  out  AW  drives rw.
- gpr_wd  out  DW  drives wd.

Behaviour:
- Reset (async, rst=1): gpr_we=0, gpr_rw=0, gpr_wd=0, every busy bit=0, round-robin last-grant pointer=NREQ-1, so index 0 wins first. Reset mid-operation discards pending grants and reservations.
- Arbitration (combinational):
  - Search starts at index last+1 and wraps modulo NREQ.
  - The first valid requester found gets req_ready=1; every other req_ready is 0.
  - No valid requester: all req_ready=0.
  - At most one grant per cycle.
- Pointer update: on a transfer, last <= granted index. With no transfer, the pointer holds.
- Output stage (1-cycle latency): on the edge ending a transfer cycle, the output stage loads:
  - gpr_rw <= granted req_rw;
  - gpr_wd <= granted req_wd;
  - gpr_we <= (granted req_rw != 0).
- With no transfer, gpr_we <= 0 and gpr_rw/gpr_wd hold their values.
- A write to register 0 is consumed (handshake completes) but never asserts gpr_we.
- Scoreboard, busy[31:0]:
  - busy[0] is constant 0.
  - Reservation: rsv_ready = rsv_valid & !busy[rsv_rw]. This stalls a write-after-write to a register that is already pending.
  - Reserving register 0 is always accepted and has no effect.
  - Accepted reservation: busy[rsv_rw] <= 1.
  - Clear: in a cycle with gpr_we=1, busy[gpr_rw] <= 0. The clear takes effect on the same edge the register file commits the data.
  - Set and clear of the same register on the same edge: the set wins and busy stays 1.
- Queries (combinational): busy_a = busy[qa], busy_b = busy[qb].
  - They report 1 through the cycle in which gpr_we is high for that register.
  - They report 0 from the following cycle.
- Back-to-back: a different requester may be granted every cycle, so the sustained rate is 1 write/cycle.
- Fairness: any requester held valid is granted within NREQ cycles.
- No ordering check between requesters. Decode ensures a single outstanding writer per register via rsv_ready.

Decomposition:
- Shared package gpr_pkg: GPR_AW=5, GPR_DW=32, GPR_NUM=32, and the zero-register index constant.
- Natural sub-module: rr_arbiter (parameter N; inputs req and advance; outputs one-hot grant; owns the last-grant pointer).
- Scoreboard and output register stay in gpr_wb_sched.

Test Plan:
- Reset outputs: assert rst mid-transfer with all req_valid=1 -> gpr_we=0, gpr_rw=0, gpr_wd=0, busy_a=busy_b=0 immediately (async).
- Round-robin: after reset hold req_valid=3'b111, destinations 1, 2, 3 with data 0xA, 0xB, 0xC.
  - Expect grants in order 0, 1, 2, 0 on consecutive cycles.
  - Expect gpr_we=1 each following cycle, with gpr_rw=1, 2, 3 and gpr_wd=0xA, 0xB, 0xC.
- Zero register: requester 1 writes rw=0, wd=0xDEAD -> req_ready[1]=1 for one cycle, gpr_we stays 0.
- Scoreboard lifecycle: reserve rw=7 (rsv_ready=1), then hold qa=7.
  - busy_a=1 until requester 2 writes rw=7.
  - busy_a=1 during the gpr_we cycle and 0 the cycle after.
- WAW stall and set/clear collision:
  - rsv_rw=7 while busy[7]=1 -> rsv_ready=0.
  - rsv_rw=7 in the exact cycle gpr_we=1 with gpr_rw=7 -> rsv_ready=0, so busy[7] clears.
  - Retry on the next cycle -> rsv_ready=1 and busy[7]=1.
- Idle hold: no req_valid for 5 cycles -> req_ready=0, gpr_we=0, pointer unchanged (the next grant goes to last+1).

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared register-file geometry for the GPR write-back path.
package gpr_pkg;

    localparam int GPR_AW  = 5;
    localparam int GPR_DW  = 32;
    localparam int GPR_NUM = 32;

    localparam logic [GPR_AW-1:0] GPR_ZERO = 5'd0;

    typedef logic [GPR_AW-1:0] gpr_addr_t;
    typedef logic [GPR_DW-1:0] gpr_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    logic [LW-1:0] last_r;
    logic [LW-1:0] grant_idx_s;
    logic [LW-1:0] idx_s;
    logic          found_s;

    // Scan requesters starting at last+1, wrapping modulo N.
    always_comb begin
        grant       = '0;
        grant_idx_s = last_r;
        found_s     = 1'b0;
        idx_s       = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s = LW'((int'(last_r) + k) % N);
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_idx_s  = idx_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Last-grant pointer; reset value makes index 0 win first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= LW'(N - 1);
        end else if (advance) begin
            last_r <= grant_idx_s;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/gpr_wb_sched.sv
// Write-back scheduler: arbitrates producers onto the GPR write port and
// tracks which registers still have a write in flight.
module gpr_wb_sched
    import gpr_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = GPR_DW,
    parameter int AW   = GPR_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*AW-1:0] req_rw,
    input  logic [NREQ*DW-1:0] req_wd,
    output logic [NREQ-1:0]  req_ready,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_rw,
    output logic             rsv_ready,
    input  logic [AW-1:0]    qa,
    input  logic [AW-1:0]    qb,
    output logic             busy_a,
    output logic             busy_b,
    output logic             gpr_we,
    output logic [AW-1:0]    gpr_rw,
    output logic [DW-1:0]    gpr_wd
);

    localparam int NREG = 1 << AW;

    logic [NREQ-1:0] grant_s;
    logic            transfer_s;
    logic [AW-1:0]   sel_rw_s;
    logic [DW-1:0]   sel_wd_s;
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (transfer_s),
        .grant   (grant_s)
    );

    assign req_ready  = grant_s;
    assign transfer_s = |(req_valid & grant_s);

    // Select the granted requester's destination and data.
    always_comb begin
        sel_rw_s = '0;
        sel_wd_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                sel_rw_s = req_rw[i*AW +: AW];
                sel_wd_s = req_wd[i*DW +: DW];
            end else begin
                sel_rw_s = sel_rw_s;
            end
        end
    end

    // Output stage: one cycle after the handshake; register 0 never writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpr_we <= 1'b0;
            gpr_rw <= '0;
            gpr_wd <= '0;
        end else if (transfer_s) begin
            gpr_we <= (sel_rw_s != AW'(GPR_ZERO));
            gpr_rw <= sel_rw_s;
            gpr_wd <= sel_wd_s;
        end else begin
            gpr_we <= 1'b0;
        end
    end

    assign rsv_ready = rsv_valid & ~busy_r[rsv_rw];
    assign busy_a    = busy_r[qa];
    assign busy_b    = busy_r[qb];

    // Clear on commit, then apply a new reservation so a same-edge set wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (gpr_we) begin
            busy_nxt_s[gpr_rw] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (rsv_ready) begin
            busy_nxt_s[rsv_rw] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Busy-register scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

endmodule
